// File: rtl/exam_nch_if.sv
// exam_nch_if: per-channel Avalon-ST sink bundle.
// Master drives data/valid, slave returns ready.
interface exam_nch_if #(
  parameter int N_CH = 3,
  parameter int W    = 8
);
  logic [N_CH*W-1:0] data;
  logic [N_CH-1:0]   valid;
  logic [N_CH-1:0]   ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/exam_nch.sv
// exam_nch: collects one word per channel, then reduces
// them (sum/max/min/xor) into a single registered result.
module exam_nch #(
  parameter int N_CH = 3,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  exam_nch_if.slave    s,
  input  logic [1:0]   mode,
  output logic [W-1:0] R,
  output logic         r_valid,
  output logic         ovf,
  output logic [15:0]  res_cnt
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_COMPUTE = 1'b1;

  logic [0:0]      r_state;
  logic [N_CH-1:0] r_full;
  logic [W-1:0]    r_slot [N_CH];
  logic [W-1:0]    r_res;
  logic            r_vld;
  logic            r_ovf;
  logic [15:0]     r_res_cnt;

  // three guard bits cover up to eight channels
  logic [W+2:0]    w_sum;
  logic [W-1:0]    w_max;
  logic [W-1:0]    w_min;
  logic [W-1:0]    w_xor;
  logic [W-1:0]    w_res;
  logic            w_ovf;

  always_comb begin
    w_sum = '0;
    w_max = '0;
    w_min = '1;
    w_xor = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + {3'b000, r_slot[i]};
      if (r_slot[i] > w_max) w_max = r_slot[i];
      if (r_slot[i] < w_min) w_min = r_slot[i];
      w_xor = w_xor ^ r_slot[i];
    end
  end

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (mode)
      2'd0: begin
        w_res = w_sum[W-1:0];
        w_ovf = |w_sum[W+2:W];
      end
      2'd1: w_res = w_max;
      2'd2: w_res = w_min;
      2'd3: w_res = w_xor;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_COLLECT;
      r_full    <= '0;
      r_res     <= '0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_res_cnt <= '0;
      for (int i = 0; i < N_CH; i++)
        r_slot[i] <= '0;
    end else begin
      r_vld <= 1'b0;
      unique case (r_state)
        ST_COLLECT: begin
          for (int i = 0; i < N_CH; i++) begin
            if (s.valid[i] && !r_full[i]) begin
              r_slot[i] <= s.data[i*W +: W];
              r_full[i] <= 1'b1;
            end
          end
          if (&r_full) r_state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          r_res     <= w_res;
          r_ovf     <= w_ovf;
          r_vld     <= 1'b1;
          r_res_cnt <= r_res_cnt + 16'd1;
          r_full    <= '0;
          r_state   <= ST_COLLECT;
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  // ready depends on registered state only
  assign s.ready = (r_state == ST_COLLECT) ? ~r_full : '0;
  assign R       = r_res;
  assign r_valid = r_vld;
  assign ovf     = r_ovf;
  assign res_cnt = r_res_cnt;

endmodule

// File: tb/tb_exam_nch.sv
// tb_exam_nch: directed vectors with a result scoreboard
// checked by an independent monitor on r_valid.
module tb_exam_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  R;
  logic        r_valid;
  logic        ovf;
  logic [15:0] res_cnt;

  typedef struct {
    logic [7:0]  r;
    logic        o;
    logic [15:0] c;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  exam_nch_if #(.N_CH(3), .W(8)) bus ();

  exam_nch #(.N_CH(3), .W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (bus),
    .mode    (mode),
    .R       (R),
    .r_valid (r_valid),
    .ovf     (ovf),
    .res_cnt (res_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got R=%0h want none", R);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_R", 32'(R), 32'(e.r));
        chk("mon_ovf", 32'(ovf), 32'(e.o));
        chk("mon_cnt", 32'(res_cnt), 32'(e.c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [7:0] er,
                            input logic er_o);
    exp_cnt = exp_cnt + 16'd1;
    q.push_back('{r: er, o: er_o, c: exp_cnt});
  endtask

  task automatic send_all(input logic [7:0] d0,
                          input logic [7:0] d1,
                          input logic [7:0] d2,
                          input logic [1:0] md,
                          input logic [7:0] er,
                          input logic       er_o);
    bus.data  = {d2, d1, d0};
    bus.valid = 3'b111;
    mode      = md;
    expect_res(er, er_o);
    step();
    bus.valid = 3'b000;
    chk("full_ready", 32'(bus.ready), 32'h0);
    step();
    chk("k1_rvalid", 32'(r_valid), 32'h0);
    chk("k1_ready", 32'(bus.ready), 32'h0);
    step();
    chk("k2_rvalid", 32'(r_valid), 32'h1);
    chk("k2_ready", 32'(bus.ready), 32'h7);
    step();
    chk("pulse_end", 32'(r_valid), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd0;
    bus.data  = '0;
    bus.valid = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'h7);
    chk("rst_R", 32'(R), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_cnt", 32'(res_cnt), 32'h0);
    chk("rst_rvalid", 32'(r_valid), 32'h0);

    send_all(8'd10, 8'd20, 8'd30, 2'd0, 8'd60, 1'b0);
    send_all(8'd200, 8'd100, 8'd5, 2'd0, 8'd49, 1'b1);

    // staggered fill with a blocked word on channel 0
    mode      = 2'd1;
    bus.data  = {8'd0, 8'd0, 8'd7};
    bus.valid = 3'b001;
    step();
    bus.data[7:0] = 8'd99;
    chk("bp_ready0", 32'(bus.ready), 32'h6);
    bus.data[23:16] = 8'd3;
    bus.valid       = 3'b101;
    step();
    chk("bp_ready1", 32'(bus.ready), 32'h2);
    bus.data[15:8] = 8'd9;
    bus.valid      = 3'b111;
    expect_res(8'd9, 1'b0);
    step();
    bus.valid = 3'b001;
    chk("bp_ready2", 32'(bus.ready), 32'h0);
    step();
    chk("bp_k1", 32'(r_valid), 32'h0);
    step();
    chk("bp_k2", 32'(r_valid), 32'h1);
    chk("bp_k2_ready", 32'(bus.ready), 32'h7);
    step();
    chk("bp_99_taken", 32'(bus.ready), 32'h6);
    bus.valid = 3'b000;
    bus.data  = {8'd2, 8'd1, 8'd0};
    bus.valid = 3'b110;
    mode      = 2'd3;
    expect_res(8'd99, 1'b0);
    step();
    mode      = 2'd1;
    bus.valid = 3'b000;
    step();
    step();
    chk("mode_late", 32'(r_valid), 32'h1);
    step();

    send_all(8'h0F, 8'hF0, 8'h3C, 2'd2, 8'h0F, 1'b0);
    send_all(8'h0F, 8'hF0, 8'h3C, 2'd3, 8'hC3, 1'b0);

    // reset mid-collect, racing a transfer on channel 2
    mode      = 2'd0;
    bus.data  = {8'd0, 8'd2, 8'd1};
    bus.valid = 3'b011;
    step();
    chk("mid_ready", 32'(bus.ready), 32'h4);
    rst       = 1'b1;
    bus.data  = {8'd5, 8'd2, 8'd1};
    bus.valid = 3'b100;
    step();
    rst       = 1'b0;
    bus.valid = 3'b000;
    exp_cnt   = 16'd0;
    chk("mid_rst_ready", 32'(bus.ready), 32'h7);
    chk("mid_rst_rvalid", 32'(r_valid), 32'h0);
    chk("mid_rst_cnt", 32'(res_cnt), 32'h0);
    send_all(8'd4, 8'd5, 8'd6, 2'd0, 8'd15, 1'b0);

    // reset while in COMPUTE
    bus.data  = {8'd1, 8'd1, 8'd1};
    bus.valid = 3'b111;
    step();
    bus.valid = 3'b000;
    step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    exp_cnt = 16'd0;
    chk("cmp_rst_rvalid", 32'(r_valid), 32'h0);
    chk("cmp_rst_R", 32'(R), 32'h0);
    chk("cmp_rst_ready", 32'(bus.ready), 32'h7);
    step();
    chk("cmp_rst_quiet", 32'(r_valid), 32'h0);

    // counter wrap
    force dut.r_res_cnt = 16'hFFFF;
    #1;
    release dut.r_res_cnt;
    exp_cnt = 16'hFFFF;
    step();
    send_all(8'd1, 8'd2, 8'd3, 2'd0, 8'd6, 1'b0);
    chk("wrap_cnt", 32'(res_cnt), 32'h0);
    send_all(8'd255, 8'd1, 8'd0, 2'd0, 8'd0, 1'b1);
    chk("wrap_next", 32'(res_cnt), 32'h1);

    step();
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exam_nch.md
EXAM_NCH -- requirements
Module: exam_nch

Interface
REQ-001 Parameter N_CH, default 3: number of Avalon-ST sink channels, legal range 2..8.
REQ-002 Parameter W, default 8: data width per channel and width of result R, legal range 4..32.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port data, input, N_CH*W bits: channel i occupies bits [i*W+W-1 : i*W].
REQ-006 Port valid, input, N_CH bits: valid[i] marks data for channel i as valid.
REQ-007 Port ready, output, N_CH bits: ready[i] means the block accepts channel i this cycle.
REQ-008 Port mode, input, 2 bits: result function (0 = sum, 1 = max, 2 = min, 3 = xor).
REQ-009 Port R, output, W bits: last computed result, held until the next result.
REQ-010 Port r_valid, output, 1 bit: one-cycle pulse when R is updated.
REQ-011 Port ovf, output, 1 bit: overflow flag for the last result, updated together with R.
REQ-012 Port res_cnt, output, 16 bits: number of results produced, wraps modulo 2^16.

Function
REQ-013 The block SHALL hold one slot register of W bits and one full flag per channel.
REQ-014 The FSM SHALL have exactly two states: COLLECT (the reset state) and COMPUTE.
REQ-015 In COLLECT, ready[i] SHALL be 1 exactly when slot i is empty; in COMPUTE, all ready bits SHALL be 0.
REQ-016 All ready bits SHALL be driven from registered state only, with no combinational path from valid or data.
REQ-017 A transfer on channel i SHALL occur on an edge where valid[i]=1 and ready[i]=1; data[i] is then written to slot i and full[i] is set.
REQ-018 When valid[i]=1 and ready[i]=0, the block SHALL not capture the data and SHALL not lose any stored slot; the source holds the data.
REQ-019 Channels SHALL fill independently, in any order; simultaneous transfers on several channels in the same cycle SHALL all be captured.
REQ-020 In COLLECT, when all full flags are 1 at an edge, the state SHALL go to COMPUTE on that edge.
REQ-021 On the edge that leaves COMPUTE, the block SHALL perform all of the following:
- R <= f(mode, slots), with mode sampled on that edge;
- ovf updated;
- r_valid <= 1 for exactly one cycle;
- res_cnt incremented;
- all full flags cleared;
- state <= COLLECT.
REQ-022 Latency: if the last slot is captured at edge k, R, ovf and r_valid SHALL be visible after edge k+2, and ready SHALL return to 1 after edge k+2.
REQ-023 Sum mode SHALL produce R = (sum of all slots) mod 2^W, and ovf = 1 exactly when the unbounded sum exceeds 2^W-1.
REQ-024 Max and min modes SHALL compare slots as unsigned values; xor mode SHALL be the bitwise xor of all slots; ovf SHALL be 0 in these three modes.
REQ-025 A change of mode while in COLLECT SHALL have no effect; only the value present on the COMPUTE exit edge matters.
REQ-026 res_cnt SHALL wrap from 16'hFFFF to 0 without any other side effect.

Reset
REQ-027 While rst=1 at an edge, the block SHALL reset as follows:
- state <= COLLECT;
- all full flags, R, ovf, r_valid and res_cnt <= 0;
- ready reads all 1 on the cycle after reset.
REQ-028 Reset in the middle of a collection or in COMPUTE SHALL discard partial slots and SHALL produce no r_valid pulse.
REQ-029 Reset SHALL take priority over any transfer happening on the same edge.

Verification
REQ-030 Scenario "sum": N_CH=3, W=8, mode=0, inputs 10, 20, 30 in one cycle -> after 2 edges R=60, ovf=0, r_valid pulses once, res_cnt=1.
REQ-031 Scenario "overflow": mode=0, inputs 200, 100, 5 -> R=49, ovf=1.
REQ-032 Scenario "staggered and backpressure": channel 0 sends 7; valid[0] stays high with 99; channels 2 and 1 send 3 and 9 on later cycles; mode=1 -> ready[0]=0 while 99 is pending, R=9, then 99 is accepted as channel 0's first word of the next result.
REQ-033 Scenario "min/xor": mode=2 with inputs 0x0F, 0xF0, 0x3C gives R=0x0F; the same inputs with mode=3 give R=0xC3.
REQ-034 Scenario "reset mid-collect": two of three slots are full, then rst is pulsed for 1 cycle -> ready=3'b111, no r_valid; the next full set of inputs produces exactly one result with res_cnt=1.
REQ-035 Scenario "wrap": res_cnt is forced to 16'hFFFF by completing 65535 results, then one more result is completed -> res_cnt=0, R is correct.
